// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: opcode field layout, NOP encoding, two-word opcodes, fetch FSM encoding.
package pipeline_pkg;

    localparam int OPCODE_W   = 5;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;

    localparam logic [15:0] NOP_INSTR         = 16'h0000;
    localparam int unsigned RESET_VECTOR_ADDR = 0;

    localparam logic [OPCODE_W-1:0] OP_LDM = 5'b10110;
    localparam logic [OPCODE_W-1:0] OP_LDD = 5'b10111;
    localparam logic [OPCODE_W-1:0] OP_STD = 5'b11000;

    typedef enum logic [1:0] {
        VECTOR = 2'd0,
        FETCH  = 2'd1,
        IMM    = 2'd2
    } fetch_state_t;

    // Opcodes whose second memory word is an immediate operand.
    function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_LDM) || (opcode == OP_LDD) || (opcode == OP_STD);
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: flush (NOP, valid=0) beats load; neither means hold.
// Latency 1 cycle; holding on stall is the caller's choice of load=flush=0.
module if_id_buffer #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                flush,
    input  logic [15:0]         next_instruction,
    input  logic [15:0]         next_immediate,
    input  logic [PC_WIDTH-1:0] next_pc,
    output logic [15:0]         instruction,
    output logic [15:0]         immediate,
    output logic [PC_WIDTH-1:0] pc_buf,
    output logic                valid
);
    import pipeline_pkg::*;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            immediate   <= '0;
            pc_buf      <= '0;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_INSTR;
            immediate   <= '0;
            pc_buf      <= '0;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= next_instruction;
            immediate   <= next_immediate;
            pc_buf      <= next_pc;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetching_stage.sv
// Instruction fetch: PC, reset-vector load, two-word assembly into IF/ID; 1-cycle latency.
// stall freezes PC/FSM/IF/ID; jump_occured overrides stall, redirects and flushes one slot.
module fetching_stage #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                stall,
    input  logic                jump_occured,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [15:0]         instruction,
    output logic [15:0]         immediate,
    output logic [PC_WIDTH-1:0] pc_buf,
    output logic                valid
);
    import pipeline_pkg::*;

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] hold_pc;
    logic [15:0]         hold_reg;
    logic                two_word;

    logic                buf_load;
    logic                buf_flush;
    logic [15:0]         buf_instr;
    logic [15:0]         buf_imm;
    logic [PC_WIDTH-1:0] buf_pc;

    assign imem_addr = (state == VECTOR) ? PC_WIDTH'(RESET_VECTOR_ADDR) : pc;
    assign two_word  = is_two_word(imem_data[OPCODE_MSB:OPCODE_LSB]);

    always_comb begin
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        buf_instr = imem_data;
        buf_imm   = '0;
        buf_pc    = pc;
        if (state == VECTOR || jump_occured) begin
            buf_flush = 1'b1;
        end else if (!stall) begin
            case (state)
                FETCH: begin
                    if (two_word) buf_flush = 1'b1;
                    else          buf_load  = 1'b1;
                end
                IMM: begin
                    buf_load  = 1'b1;
                    buf_instr = hold_reg;
                    buf_imm   = imem_data;
                    buf_pc    = hold_pc;
                end
                default: buf_flush = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= VECTOR;
            pc       <= '0;
            hold_pc  <= '0;
            hold_reg <= NOP_INSTR;
        end else if (state == VECTOR) begin
            pc    <= PC_WIDTH'(imem_data);
            state <= FETCH;
        end else if (jump_occured) begin
            // Any half-assembled two-word instruction is abandoned.
            pc       <= jump_target;
            state    <= FETCH;
            hold_reg <= NOP_INSTR;
        end else if (!stall) begin
            case (state)
                FETCH: begin
                    pc <= pc + PC_WIDTH'(1);
                    if (two_word) begin
                        hold_reg <= imem_data;
                        hold_pc  <= pc;
                        state    <= IMM;
                    end
                end
                IMM: begin
                    pc    <= pc + PC_WIDTH'(1);
                    state <= FETCH;
                end
                default: state <= VECTOR;
            endcase
        end
    end

    if_id_buffer #(.PC_WIDTH(PC_WIDTH)) u_if_id (
        .clk              (clk),
        .reset            (reset),
        .load             (buf_load),
        .flush            (buf_flush),
        .next_instruction (buf_instr),
        .next_immediate   (buf_imm),
        .next_pc          (buf_pc),
        .instruction      (instruction),
        .immediate        (immediate),
        .pc_buf           (pc_buf),
        .valid            (valid)
    );

endmodule

// File: tb/tb_fetching_stage.sv
// Bench for fetching_stage: directed scenarios with literal expectations plus a randomized run
// compared every cycle against an instruction-level reference model.
module tb_fetching_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        jump_occured = 1'b0;
    logic [15:0] jump_target = 16'h0;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic [15:0] pc_buf;
    logic        valid;

    logic [15:0] mem [0:65535];

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetching_stage #(.PC_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .jump_occured (jump_occured),
        .jump_target  (jump_target),
        .instruction  (instruction),
        .immediate    (immediate),
        .pc_buf       (pc_buf),
        .valid        (valid)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: tracks "have we read the vector yet", the next address,
    // and whether a first word is waiting for its immediate.
    bit          m_started = 1'b0;
    bit          m_pend    = 1'b0;
    logic [15:0] m_pc      = 16'h0;
    logic [15:0] m_first   = 16'h0;
    logic [15:0] m_first_pc = 16'h0;
    logic [15:0] m_instr   = 16'h0;
    logic [15:0] m_imm     = 16'h0;
    logic [15:0] m_pcb     = 16'h0;
    bit          m_vld     = 1'b0;

    function automatic logic [15:0] m_addr();
        return m_started ? m_pc : 16'h0000;
    endfunction

    function automatic bit needs_imm(input logic [15:0] w);
        int op;
        op = int'(w >> 11);
        return (op >= 22) && (op <= 24);
    endfunction

    task automatic m_bubble();
        m_instr = 16'h0; m_imm = 16'h0; m_pcb = 16'h0; m_vld = 1'b0;
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_started = 1'b0; m_pend = 1'b0; m_pc = 16'h0;
            m_bubble();
        end else begin
            logic [15:0] w;
            w = mem[m_addr()];
            if (!m_started) begin
                m_pc = w; m_started = 1'b1;
                m_bubble();
            end else if (jump_occured) begin
                m_pc = jump_target; m_pend = 1'b0;
                m_bubble();
            end else if (!stall) begin
                if (m_pend) begin
                    m_instr = m_first; m_imm = w; m_pcb = m_first_pc; m_vld = 1'b1;
                    m_pend = 1'b0;
                end else if (needs_imm(w)) begin
                    m_first = w; m_first_pc = m_pc; m_pend = 1'b1;
                    m_bubble();
                end else begin
                    m_instr = w; m_imm = 16'h0; m_pcb = m_pc; m_vld = 1'b1;
                end
                m_pc = m_pc + 16'h1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_imem_addr",   imem_addr,   m_addr());
        chk("model_instruction", instruction, m_instr);
        chk("model_immediate",   immediate,   m_imm);
        chk("model_pc_buf",      pc_buf,      m_pcb);
        chk("model_valid",       16'(valid),  16'(m_vld));
    end

    task automatic do_reset();
        @(negedge clk);
        stall = 1'b0; jump_occured = 1'b0; jump_target = 16'h0;
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_two_word_prog();
        mem[16'h0000] = 16'h0010;
        mem[16'h0010] = 16'hB100;
        mem[16'h0011] = 16'hBEEF;
        mem[16'h0012] = 16'h1120;
        mem[16'h0013] = 16'h2222;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        // Reset vector, single-word target
        mem[16'h0000] = 16'h0010;
        mem[16'h0010] = 16'h1120;
        mem[16'h0011] = 16'h1120;
        @(negedge clk); #2;
        chk("rst_instruction", instruction, 16'h0000);
        chk("rst_immediate",   immediate,   16'h0000);
        chk("rst_pc_buf",      pc_buf,      16'h0000);
        chk("rst_valid",       16'(valid),  16'h0000);
        @(negedge clk); reset = 1'b1; #1;
        chk("vec_addr", imem_addr, 16'h0000);
        @(negedge clk); #1;
        chk("vec_first_addr", imem_addr, 16'h0010);
        chk("vec_bubble", 16'(valid), 16'h0000);
        @(negedge clk); #1;
        chk("vec_instr", instruction, 16'h1120);
        chk("vec_pc_buf", pc_buf, 16'h0010);
        chk("vec_valid", 16'(valid), 16'h0001);

        // Two-word fetch
        load_two_word_prog();
        do_reset();
        @(negedge clk); #1;
        chk("tw_addr0", imem_addr, 16'h0010);
        @(negedge clk); #1;
        chk("tw_addr1", imem_addr, 16'h0011);
        chk("tw_bubble", 16'(valid), 16'h0000);
        @(negedge clk); #1;
        chk("tw_instr", instruction, 16'hB100);
        chk("tw_imm",   immediate,   16'hBEEF);
        chk("tw_pcbuf", pc_buf,      16'h0010);
        chk("tw_valid", 16'(valid),  16'h0001);
        @(negedge clk); #1;
        chk("tw_next_instr", instruction, 16'h1120);
        chk("tw_next_imm",   immediate,   16'h0000);
        chk("tw_next_pcbuf", pc_buf,      16'h0012);

        // Stall while in IMM, then while a valid instruction sits in IF/ID
        do_reset();
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("stall_imm_addr",  imem_addr,  16'h0011);
            chk("stall_imm_valid", 16'(valid), 16'h0000);
        end
        stall = 1'b0;
        @(negedge clk); #1;
        chk("stall_imm_instr", instruction, 16'hB100);
        chk("stall_imm_imm",   immediate,   16'hBEEF);
        @(negedge clk); #1;
        chk("stall_resume_pcbuf", pc_buf, 16'h0012);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("stall_fetch_addr",  imem_addr,   16'h0013);
            chk("stall_fetch_instr", instruction, 16'h1120);
            chk("stall_fetch_pcbuf", pc_buf,      16'h0012);
        end
        stall = 1'b0;
        @(negedge clk); #1;
        chk("stall_fetch_next", instruction, 16'h2222);
        chk("stall_fetch_next_pc", pc_buf, 16'h0013);

        // Jump together with stall while in IMM
        mem[16'h0040] = 16'h2345;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        jump_occured = 1'b1; stall = 1'b1; jump_target = 16'h0040;
        @(negedge clk); #1;
        jump_occured = 1'b0; stall = 1'b0;
        chk("jump_addr",   imem_addr,  16'h0040);
        chk("jump_bubble", 16'(valid), 16'h0000);
        @(negedge clk); #1;
        chk("jump_instr", instruction, 16'h2345);
        chk("jump_pcbuf", pc_buf,      16'h0040);
        chk("jump_valid", 16'(valid),  16'h0001);

        // PC wrap: two-word instruction at FFFF takes its immediate from word 0
        mem[16'h0000] = 16'hFFFF;
        mem[16'hFFFF] = 16'hB200;
        mem[16'h0001] = 16'h1120;
        do_reset();
        @(negedge clk); #1;
        chk("wrap_addr0", imem_addr, 16'hFFFF);
        @(negedge clk); #1;
        chk("wrap_addr1", imem_addr, 16'h0000);
        @(negedge clk); #1;
        chk("wrap_instr", instruction, 16'hB200);
        chk("wrap_imm",   immediate,   16'hFFFF);
        chk("wrap_pcbuf", pc_buf,      16'hFFFF);
        @(negedge clk); #1;
        chk("wrap_next_pcbuf", pc_buf, 16'h0001);

        // Async reset while in IMM
        load_two_word_prog();
        mem[16'h0012] = 16'hB300;
        mem[16'h0013] = 16'h1234;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        chk("ar_pre_instr", instruction, 16'hB100);
        @(negedge clk); #1;
        chk("ar_imm_addr", imem_addr, 16'h0013);
        #1 reset = 1'b0; #1;
        chk("ar_addr",  imem_addr,   16'h0000);
        chk("ar_instr", instruction, 16'h0000);
        chk("ar_pcbuf", pc_buf,      16'h0000);
        chk("ar_valid", 16'(valid),  16'h0000);
        @(negedge clk); reset = 1'b1; #1;
        chk("ar_vec_addr", imem_addr, 16'h0000);
        @(negedge clk); #1;
        chk("ar_refetch_addr", imem_addr, 16'h0010);

        // Randomized run
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 99) < 30)
                w[15:11] = 5'(22 + $urandom_range(0, 2));
            mem[i] = w;
        end
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                stall = 1'b0; jump_occured = 1'b0;
                #2 reset = 1'b0; #1;
                chk("rand_ar_addr",  imem_addr,  16'h0000);
                chk("rand_ar_valid", 16'(valid), 16'h0000);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                stall        = ($urandom_range(0, 99) < 25);
                jump_occured = ($urandom_range(0, 99) < 8);
                if ($urandom_range(0, 3) == 0)
                    jump_target = 16'hFFF0 | 16'($urandom_range(0, 15));
                else
                    jump_target = 16'($urandom);
            end
        end
        @(negedge clk);
        stall = 1'b0; jump_occured = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
